// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass and a per-register busy
// scoreboard that issue logic uses for RAW/WAW hazard detection.
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int AW         = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         alloc_en,
    input  logic [AW-1:0]                alloc_addr,
    output logic                         alloc_ok,
    input  logic                         flush,
    output logic [REG_COUNT-1:0]         busy_vec
);

    logic [DATA_WIDTH-1:0] regs   [REG_COUNT];
    logic [DATA_WIDTH-1:0] wr_val [REG_COUNT];
    logic [REG_COUNT-1:0]  wr_hit;
    logic [REG_COUNT-1:0]  busy_q;

    // Per-register write decode; later ports override earlier ones so the
    // highest-index port wins a collision. Out-of-range addresses match nothing.
    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)
                    && !(ZERO_REG != 0 && r == 0)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (rd_addr[i*AW +: AW] == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                        (BYPASS != 0 && wr_hit[r]) ? wr_val[r] : regs[r];
                    rd_busy[i] = busy_q[r] && !(BYPASS != 0 && wr_hit[r]);
                end
            end
        end
    end

    // A same-cycle writeback deliberately does not free the register for allocation.
    always_comb begin
        alloc_ok = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (alloc_addr == AW'(r))
                alloc_ok = !busy_q[r] || (ZERO_REG != 0 && r == 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++)
                regs[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
                if (flush)
                    busy_q[r] <= 1'b0;
                else if (alloc_en && alloc_ok && alloc_addr == AW'(r)
                         && !(ZERO_REG != 0 && r == 0))
                    busy_q[r] <= 1'b1;
                else if (wr_hit[r])
                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: default instance plus a no-bypass,
// ordinary-r0, 24-entry instance sharing the same stimulus.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        alloc_ok, alloc_ok_nb;
    logic        flush;
    logic [31:0] busy_vec;
    logic [23:0] busy_vec_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok),
        .flush(flush), .busy_vec(busy_vec)
    );

    regfile_mp_sb #(.REG_COUNT(24), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_nb),
        .flush(flush), .busy_vec(busy_vec_nb)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0, ra1;
        logic        ae;
        logic [4:0]  aa;
        logic        fl;
        logic [31:0] e_rd0, e_rd1;
        logic [1:0]  e_rb;
        logic        e_ok;
        logic [31:0] e_bv;
        logic [31:0] e_nb1;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t v(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                               logic [4:0] wa1, logic [31:0] wd1,
                               logic [4:0] ra0, logic [4:0] ra1,
                               logic ae, logic [4:0] aa, logic fl,
                               logic [31:0] e_rd0, logic [31:0] e_rd1,
                               logic [1:0] e_rb, logic e_ok,
                               logic [31:0] e_bv, logic [31:0] e_nb1);
        vec_t t;
        t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
        t.ra0 = ra0; t.ra1 = ra1; t.ae = ae; t.aa = aa; t.fl = fl;
        t.e_rd0 = e_rd0; t.e_rd1 = e_rd1; t.e_rb = e_rb; t.e_ok = e_ok;
        t.e_bv = e_bv; t.e_nb1 = e_nb1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        wr_en      = t.we;
        wr_addr    = {t.wa1, t.wa0};
        wr_data    = {t.wd1, t.wd0};
        rd_addr    = {t.ra1, t.ra0};
        alloc_en   = t.ae;
        alloc_addr = t.aa;
        flush      = t.fl;
    endtask

    task automatic idle();
        drive(v(0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0));
    endtask

    initial begin
        vecs[0]  = v(2'b00, 0,0, 0,0,                  0,0, 0,0,0, 0,0,                    0,1,32'h0,   0);
        vecs[1]  = v(2'b01, 5,32'hDEADBEEF, 0,0,       5,0, 0,0,0, 32'hDEADBEEF,0,         0,1,32'h0,   0);
        vecs[2]  = v(2'b00, 0,0, 0,0,                  5,5, 0,0,0, 32'hDEADBEEF,32'hDEADBEEF,0,1,32'h0, 32'hDEADBEEF);
        vecs[3]  = v(2'b00, 0,0, 0,0,                  0,0, 0,0,0, 0,0,                    0,1,32'h0,   0);
        vecs[4]  = v(2'b01, 7,32'h12345678, 0,0,       5,7, 0,0,0, 32'hDEADBEEF,32'h12345678,0,1,32'h0, 0);
        vecs[5]  = v(2'b11, 3,32'hAAAA, 3,32'h5555,    3,7, 0,0,0, 32'h5555,32'h12345678,  0,1,32'h0,   32'h12345678);
        vecs[6]  = v(2'b01, 0,32'hFFFF, 0,0,           3,0, 0,0,0, 32'h5555,0,             0,1,32'h0,   0);
        vecs[7]  = v(2'b00, 0,0, 0,0,                  3,0, 0,0,0, 32'h5555,0,             0,1,32'h0,   32'hFFFF);
        vecs[8]  = v(2'b00, 0,0, 0,0,                  9,9, 1,9,0, 0,0,                    0,1,32'h0,   0);
        vecs[9]  = v(2'b00, 0,0, 0,0,                  9,9, 1,9,0, 0,0,                    3,0,32'h200, 0);
        vecs[10] = v(2'b00, 0,0, 0,0,                  9,9, 0,9,0, 0,0,                    3,0,32'h200, 0);
        vecs[11] = v(2'b10, 0,0, 9,32'h42,             9,9, 0,9,0, 32'h42,32'h42,          0,0,32'h200, 0);
        vecs[12] = v(2'b00, 0,0, 0,0,                  9,9, 0,9,0, 32'h42,32'h42,          0,1,32'h0,   32'h42);
        vecs[13] = v(2'b01, 4,32'h44, 0,0,             4,4, 1,4,0, 32'h44,32'h44,          0,1,32'h0,   0);
        vecs[14] = v(2'b00, 0,0, 0,0,                  4,4, 1,0,0, 32'h44,32'h44,          3,1,32'h10,  32'h44);
        vecs[15] = v(2'b00, 0,0, 0,0,                  0,4, 0,0,0, 0,32'h44,               2,1,32'h10,  32'h44);
        vecs[16] = v(2'b00, 0,0, 0,0,                  1,2, 1,1,0, 0,0,                    0,1,32'h10,  0);
        vecs[17] = v(2'b00, 0,0, 0,0,                  1,2, 1,2,0, 0,0,                    1,1,32'h12,  0);
        vecs[18] = v(2'b00, 0,0, 0,0,                  1,2, 1,3,0, 0,0,                    3,1,32'h16,  0);
        vecs[19] = v(2'b01, 2,32'h99, 0,0,             1,2, 0,3,1, 0,32'h99,               1,0,32'h1E,  0);
        vecs[20] = v(2'b00, 0,0, 0,0,                  2,3, 0,3,0, 32'h99,32'h5555,        0,1,32'h0,   32'h5555);
        vecs[21] = v(2'b00, 0,0, 0,0,                  0,0, 1,6,1, 0,0,                    0,1,32'h0,   32'hFFFF);
        vecs[22] = v(2'b00, 0,0, 0,0,                  0,0, 0,6,0, 0,0,                    0,1,32'h0,   32'hFFFF);

        rst_n = 1'b0;
        idle();
        #2;
        chk("reset rd_data",  rd_data[31:0], 32'h0);
        chk("reset rd_busy",  {30'd0, rd_busy}, 32'h0);
        chk("reset alloc_ok", {31'd0, alloc_ok}, 32'h1);
        chk("reset busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            chk($sformatf("v%0d rd0", k), rd_data[31:0], vecs[k].e_rd0);
            chk($sformatf("v%0d rd1", k), rd_data[63:32], vecs[k].e_rd1);
            chk($sformatf("v%0d rd_busy", k), {30'd0, rd_busy}, {30'd0, vecs[k].e_rb});
            chk($sformatf("v%0d alloc_ok", k), {31'd0, alloc_ok}, {31'd0, vecs[k].e_ok});
            chk($sformatf("v%0d busy_vec", k), busy_vec, vecs[k].e_bv);
            chk($sformatf("v%0d nb rd1", k), rd_data_nb[63:32], vecs[k].e_nb1);
        end

        // Out-of-range address 30 on the 24-entry instance, in range on the default one.
        @(negedge clk);
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd30}; wr_data = {32'h0, 32'h77};
        rd_addr = {5'd30, 5'd30}; alloc_addr = 5'd30;
        #1;
        chk("oor nb rd0",      rd_data_nb[31:0], 32'h0);
        chk("oor nb alloc_ok", {31'd0, alloc_ok_nb}, 32'h0);
        chk("oor bypass rd0",  rd_data[31:0], 32'h77);
        @(negedge clk);
        idle();
        rd_addr = {5'd30, 5'd30}; alloc_addr = 5'd30;
        #1;
        chk("oor nb rd0 after", rd_data_nb[31:0], 32'h0);
        chk("oor nb rd_busy",   {30'd0, rd_busy_nb}, 32'h0);
        chk("oor stored r30",   rd_data[63:32], 32'h77);

        // Asynchronous reset in the middle of a cycle with a pending write.
        @(negedge clk);
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd6;
        @(posedge clk);
        #1;
        chk("pre-reset busy_vec", busy_vec, 32'h40);
        #2;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd8}; wr_data = {32'h0, 32'h88};
        alloc_en = 1'b0; rd_addr = {5'd3, 5'd5};
        rst_n = 1'b0;
        #1;
        chk("mid-reset busy_vec", busy_vec, 32'h0);
        chk("mid-reset r5",       rd_data[31:0], 32'h0);
        chk("mid-reset r3",       rd_data[63:32], 32'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        rd_addr = {5'd9, 5'd8};
        #1;
        chk("post-reset r8", rd_data[31:0], 32'h0);
        chk("post-reset r9", rd_data[63:32], 32'h0);
        chk("post-reset alloc_ok", {31'd0, alloc_ok}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Multi-port, parametrised general-purpose register file for the pipelined core. It adds three things to the plain 2R1W regfile:
- configurable numbers of read and write ports;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard that issue logic uses for RAW/WAW hazard detection.

It sits between decode/issue (reads, allocation) and writeback (writes, busy clear).

Parameters:
DATA_WIDTH, 32, width of each register
REG_COUNT, 32, number of registers; AW = $clog2(REG_COUNT)
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
ZERO_REG, 1, 1: register 0 hardwired to zero; 0: register 0 is ordinary
BYPASS, 1, 1: reads see same-cycle writes; 0: reads see stored value only

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NUM_RD  port i's register has a pending producer
wr_en  in  NUM_WR  write enable per port
wr_addr  in  NUM_WR*AW  write addresses, packed as rd_addr
wr_data  in  NUM_WR*DATA_WIDTH  write data, packed as rd_data
alloc_en  in  1  mark alloc_addr busy (instruction issued, destination pending)
alloc_addr  in  AW  register to allocate
alloc_ok  out  1  allocation is accepted this cycle
flush  in  1  clear all busy bits (pipeline squash)
busy_vec  out  REG_COUNT  registered scoreboard state

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, busy_vec = 0. Outputs then follow combinationally from that state:
  - rd_data = 0, rd_busy = 0, alloc_ok = 1.
- Write (posedge clk):
  - for each port with wr_en set, the register at wr_addr takes wr_data.
  - Multiple ports writing the same address in one cycle: the highest-index port wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Read: combinational, 0-cycle latency.
  - If ZERO_REG=1 and addr==0: rd_data = 0.
  - Else if BYPASS=1 and any wr_en port targets addr this cycle: rd_data = wr_data of the highest-index such port.
  - Else: rd_data = stored value.
- Write hit: wr_en[j] && wr_addr[j]==a && !(ZERO_REG && a==0).
- rd_busy[i] = busy_vec[addr_i] && !(BYPASS && write hit on addr_i).
  - ZERO_REG=1 and addr 0: rd_busy always 0.
- alloc_ok = !busy_vec[alloc_addr] || (ZERO_REG && alloc_addr==0).
  - alloc_ok does not depend on alloc_en.
  - A same-cycle writeback does not make alloc_ok true.
- Busy next-state, per register r, priority highest first:
  1. flush → 0.
  2. alloc_en && alloc_ok && alloc_addr==r && !(ZERO_REG && r==0) → 1. A new producer overrides a same-cycle writeback.
  3. Write hit on r → 0.
  4. Otherwise hold.
- alloc_en with alloc_ok=0: no busy change. Issue logic must stall and retry.
- Flush does not block data writes; those complete normally in the same cycle.
- Asynchronous reset mid-operation: all state clears immediately. No write or alloc in that cycle takes effect.
- Any out-of-range address (REG_COUNT not a power of 2):
  - writes are ignored;
  - reads return 0 and rd_busy=0;
  - alloc_ok=0.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 on port 0; next cycle read r5 on both read ports → rd_data 0xDEADBEEF on both. Reads of r0 → 0.
- Bypass: in one cycle wr_en[0]=1, wr_addr=r7, wr_data=0x12345678, rd_addr[1]=r7 → rd_data[1]=0x12345678 in that same cycle. With BYPASS=0 the same stimulus returns the old value (0).
- Write collision: port 0 writes r3=0xAAAA and port 1 writes r3=0x5555 in the same cycle → r3=0x5555. A write to r0 with ZERO_REG=1 → r0 still reads 0.
- Scoreboard sequence:
  - alloc r9 → busy_vec[9]=1;
  - a second alloc r9 → alloc_ok=0 and no change;
  - read r9 → rd_busy=1;
  - writeback r9=0x42 → bypassed read gives 0x42 with rd_busy=0 that cycle, then busy_vec[9]=0.
- Same cycle alloc r4 (r4 free) and writeback r4 → busy_vec[4]=1 and r4 updated. Alloc r0 → alloc_ok=1, busy_vec[0] stays 0.
- Allocate r1, r2, r3, then flush together with writeback r2=0x99 → busy_vec=0 and r2=0x99. Assert rst_n mid-cycle → all registers read 0 immediately.
